seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//   Multi-cycle 32-bit shift unit for the ALU.
//   Produces SLL, SRL, SRA and ROR results by applying one single-bit shift per clock, up to 31 positions.
//   Sits between the ALU control path and the ALU result mux.
//   Replaces a barrel shifter with a small iterative datapath and a start/done handshake.
// PARAMETERS
//   WIDTH  32  data width in bits
//   SHW    5   shift-amount width; must equal clog2(WIDTH)
// PORTS
//   clk    in   1      system clock; all state updates on the rising edge
//   rst_n  in   1      reset, synchronous and active-low
//   start  in   1      request; sampled only in IDLE or DONE
//   op     in   2      00=SLL, 01=SRL, 10=SRA, 11=ROR; latched with start
//   amt    in   SHW    shift amount 0..WIDTH-1; latched with start
//   din    in   WIDTH  operand; latched with start
//   busy   out  1      high while in SHIFT
//   done   out  1      one-cycle pulse; dout valid from this cycle
//   dout   out  WIDTH  result; held until the next accepted start
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//     state=IDLE, busy=0, done=0, dout=0, internal acc/count/op cleared.
//     Applies mid-operation too: the operation in flight is abandoned and no done is issued.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE:  start=1 -> load acc=din, cnt=amt, opr=op.
//            Then go to DONE if amt==0, else go to SHIFT.
//     SHIFT: each cycle, acc = 1-bit step of acc and cnt = cnt-1.
//            When cnt==1 at that edge, go to DONE; the final step is included.
//            start is ignored in SHIFT.
//     DONE:  done=1 for this cycle and dout=acc.
//            start=1 here is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
//   One-step definitions (bit i of the next value):
//     SLL: n[i]=acc[i-1] for i>0, n[0]=0
//     SRL: n[i]=acc[i+1] for i<WIDTH-1, n[WIDTH-1]=0
//     SRA: as SRL but n[WIDTH-1]=acc[WIDTH-1]
//     ROR: as SRL but n[WIDTH-1]=acc[0]
//   Timing:
//     Start sampled in cycle T -> done high in cycle T+amt+1, for every amt including 0.
//     busy is high in cycles T+1..T+amt, and never high at the same time as done.
//   Output registers:
//     dout is registered; it updates only on entry to DONE and is held in IDLE.
//     done is 0 in every state except DONE.
//   Operand handling:
//     din, op and amt may change freely after acceptance; only the latched copies are used.
//     amt is unsigned; no value is out of range for SHW=5, WIDTH=32.
// TESTING
//   1. SLL din=0x0000_0001, amt=4, start@T -> busy T+1..T+4; done@T+5, dout=0x0000_0010.
//   2. SRA din=0x8000_0000, amt=31 -> done@T+32, dout=0xFFFF_FFFF.
//      Same operand with SRL -> dout=0x0000_0001.
//   3. ROR din=0x0000_0001, amt=1 -> done@T+2, dout=0x8000_0000.
//      amt=0 with din=0xDEAD_BEEF -> done@T+1, dout=0xDEAD_BEEF, busy never high.
//   4. SRL din=0xF000_0000, amt=8; pulse start with different operands at T+3
//      -> second start ignored; done@T+9 with dout=0x00F0_0000.
//   5. SLL amt=10 started; rst_n=0 at T+4 -> from T+5 busy=0, done=0, dout=0.
//      No done pulse follows.
//   6. Hold start=1 in the DONE cycle of test 1 with SRL din=0x100, amt=8
//      -> new op accepted; the next done comes 9 cycles later with dout=0x1.

Source files
------------

// File: rtl/seq_shifter.sv
// Iterative 32-bit shifter (SLL/SRL/SRA/ROR), one bit position per clock.
// Latency: done pulses amt+1 cycles after start is accepted (amt=0 -> next cycle).
// Handshake: start is accepted in IDLE or DONE only and is ignored while busy.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_opr;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_next;
  logic             w_accept;

  // Single-bit step of the accumulator for the latched operation.
  always_comb begin
    w_next = r_acc;
    case (r_opr)
      OP_SLL:  w_next = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_next = {1'b0, r_acc[WIDTH-1:1]};
      OP_SRA:  w_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_next = {r_acc[0], r_acc[WIDTH-1:1]};
    endcase
  end

  // A new request is only taken when no shift is in progress.
  always_comb begin
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Control FSM plus datapath; busy/done/dout are all registered so they
  // change together on the state transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_opr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_acc <= din;
            r_cnt <= amt;
            r_opr <= op;
            if (amt == '0) begin
              // Zero shift: result is the operand itself, no SHIFT cycles.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_dout  <= din;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_acc <= w_next;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            // Final step lands straight in dout on entry to DONE.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dout  <= w_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: inputs driven and outputs sampled on the
// falling edge; each op is tracked cycle by cycle against the expected
// busy/done timing and the hand-computed result.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amt;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .amt   (amt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request during the current cycle, then drop start (and scramble
  // the operands) at the next falling edge, which is cycle T+1.
  task automatic launch(input logic [1:0] o, input logic [4:0] a, input logic [31:0] d);
    op    = o;
    amt   = a;
    din   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    amt   = ~a;
    din   = ~d;
  endtask

  // Called in cycle T+1. Expect busy=1/done=0 for cycles T+1..T+a, then
  // done=1/busy=0 with the result in cycle T+a+1. Returns in the done cycle.
  // inj>0 pulses start with foreign operands in cycle T+inj.
  task automatic track(input string tag, input int a, input logic [31:0] exp, input int inj);
    for (int c = 1; c <= a; c++) begin
      check({tag, " busy/done in shift"}, {30'd0, busy, done}, 32'h2);
      if (c == inj) begin
        op    = 2'b00;
        amt   = 5'd1;
        din   = 32'hFFFF_FFFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy/done at done"}, {30'd0, busy, done}, 32'h1);
    check({tag, " dout"}, dout, exp);
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    amt   = 5'd0;
    din   = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dout", dout, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle done", {31'd0, done}, 32'd0);

    // 1: SLL 1 by 4, then 6: back-to-back SRL 0x100 by 8 from the DONE cycle
    launch(2'b00, 5'd4, 32'h0000_0001);
    track("t1 sll4", 4, 32'h0000_0010, 0);
    launch(2'b01, 5'd8, 32'h0000_0100);
    track("t6 b2b srl8", 8, 32'h0000_0001, 0);
    @(negedge clk);
    check("t6 idle done", {31'd0, done}, 32'd0);
    check("t6 dout held", dout, 32'h0000_0001);

    // 2: SRA / SRL of 0x8000_0000 by 31
    launch(2'b10, 5'd31, 32'h8000_0000);
    track("t2 sra31", 31, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    check("t2 dout held", dout, 32'hFFFF_FFFF);
    launch(2'b01, 5'd31, 32'h8000_0000);
    track("t2 srl31", 31, 32'h0000_0001, 0);
    @(negedge clk);

    // 3: ROR by 1, and amt=0 passthrough
    launch(2'b11, 5'd1, 32'h0000_0001);
    track("t3 ror1", 1, 32'h8000_0000, 0);
    @(negedge clk);
    launch(2'b01, 5'd0, 32'hDEAD_BEEF);
    track("t3 amt0", 0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("t3 amt0 after busy", {31'd0, busy}, 32'd0);

    // Extra patterns: ROR wrap of a mixed value, SLL pushing bits out the top
    launch(2'b11, 5'd4, 32'h1234_5678);
    track("ror4", 4, 32'h8123_4567, 0);
    @(negedge clk);
    launch(2'b00, 5'd31, 32'h0000_0003);
    track("sll31", 31, 32'h8000_0000, 0);
    @(negedge clk);

    // 4: start pulsed mid-shift must be ignored
    launch(2'b01, 5'd8, 32'hF000_0000);
    track("t4 srl8 inj", 8, 32'h00F0_0000, 3);
    @(negedge clk);
    check("t4 idle done", {31'd0, done}, 32'd0);

    // 5: reset in the middle of a shift abandons it
    launch(2'b00, 5'd10, 32'h0000_0001);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5 busy after rst", {31'd0, busy}, 32'd0);
    check("t5 done after rst", {31'd0, done}, 32'd0);
    check("t5 dout after rst", dout, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) saw_done++;
      @(negedge clk);
    end
    check("t5 no done after rst", saw_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
